ps2_frame_rx: RTL and testbench

PS2_FRAME_RX -- requirements
Module: ps2_frame_rx

---
 rtl/ps2_frame_rx_if.sv | 12 +
 rtl/ps2_frame_rx.sv | 81 ++++++++
 tb/tb_ps2_frame_rx.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/ps2_frame_rx_if.sv
// ps2_frame_rx_if: PS/2 line inputs, receive enable and received-byte outputs.
interface ps2_frame_rx_if;
  logic ps2d;
  logic ps2c;
  logic rx_en;
  logic rx_done_tick;
  logic parity_err;
  logic frame_err;
  logic [7:0] dout;
  modport master(output ps2d, ps2c, rx_en, input rx_done_tick, dout, parity_err, frame_err);
  modport slave(input ps2d, ps2c, rx_en, output rx_done_tick, dout, parity_err, frame_err);
endinterface

// File: rtl/ps2_frame_rx.sv
// ps2_frame_rx: PS/2 device-to-host frame receiver with clock glitch filter, parity/stop checks and inter-edge timeout.
module ps2_frame_rx #(
  parameter int FILTER_LEN  = 8,
  parameter int TIMEOUT_CYC = 100000
) (
  input logic clk,
  input logic reset,
  ps2_frame_rx_if.slave bus
);
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  typedef enum logic [1:0] {IDLE, RECV, LOAD} state_t;
  state_t state_q, state_d;
  logic [1:0] c_sync_q, d_sync_q;
  logic [FILTER_LEN-1:0] filt_q, filt_d;
  logic fc_q, fc_d;
  logic fall_edge, bit_s, timeout, load, par_ok;
  logic [3:0] cnt_q, cnt_d;
  logic [TW-1:0] to_q, to_d;
  logic [9:0] sh_q, sh_d;
  logic [7:0] dout_q;
  assign filt_d = FILTER_LEN'({c_sync_q[1], filt_q} >> 1);
  assign fc_d = (filt_q == '0) ? 1'b0 : (&filt_q) ? 1'b1 : fc_q;
  assign fall_edge = fc_q & ~fc_d;
  assign bit_s = d_sync_q[1];
  always_ff @(posedge clk) begin
    if (reset) begin
      c_sync_q <= '1;
      d_sync_q <= '1;
      filt_q <= '1;
      fc_q <= 1'b1;
      state_q <= IDLE;
      cnt_q <= '0;
      to_q <= '0;
      sh_q <= '0;
      dout_q <= '0;
    end else begin
      c_sync_q <= {c_sync_q[0], bus.ps2c};
      d_sync_q <= {d_sync_q[0], bus.ps2d};
      filt_q <= filt_d;
      fc_q <= fc_d;
      state_q <= state_d;
      cnt_q <= cnt_d;
      to_q <= to_d;
      sh_q <= sh_d;
      dout_q <= bus.dout;
    end
  end
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    to_d = to_q;
    sh_d = sh_q;
    timeout = 1'b0;
    case (state_q)
      IDLE: if (fall_edge && bus.rx_en && !bit_s) begin
        state_d = RECV;
        cnt_d = 4'd10;
        to_d = '0;
      end
      RECV: if (fall_edge) begin
        sh_d = {bit_s, sh_q[9:1]};
        cnt_d = cnt_q - 4'd1;
        to_d = '0;
        state_d = (cnt_q == 4'd1) ? LOAD : RECV;
      end else if (to_q == TW'(TIMEOUT_CYC - 1)) begin
        timeout = 1'b1;
        state_d = IDLE;
      end else begin
        to_d = to_q + TW'(1);
      end
      default: state_d = IDLE;
    endcase
  end
  // sh_q holds {stop, parity, d7..d0} once LOAD is reached
  assign load = state_q == LOAD;
  assign par_ok = ^sh_q[8:0];
  assign bus.frame_err = (load & ~sh_q[9]) | timeout;
  assign bus.parity_err = load & sh_q[9] & ~par_ok;
  assign bus.rx_done_tick = load & sh_q[9] & par_ok;
  assign bus.dout = bus.rx_done_tick ? sh_q[7:0] : dout_q;
endmodule

// File: tb/tb_ps2_frame_rx.sv
// tb_ps2_frame_rx: vector table, directed corner sequences and random frames against a frame-level reference model.
module tb_ps2_frame_rx;
  localparam int FL = 8;
  localparam int TO = 300;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int cyc = 0;
  int n_cmp = 0;
  int n_fail = 0;
  int multi = 0;
  int dout_bad = 0;
  int done_q[$];
  int perr_q[$];
  int ferr_q[$];
  logic [7:0] val_q[$];
  logic [7:0] last_dout = 8'h00;
  logic [7:0] exp_dout = 8'h00;
  ps2_frame_rx_if bus();
  ps2_frame_rx #(.FILTER_LEN(FL), .TIMEOUT_CYC(TO)) dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    if (bus.rx_done_tick === 1'b1) begin
      done_q.push_back(cyc);
      val_q.push_back(bus.dout);
    end
    if (bus.parity_err === 1'b1) perr_q.push_back(cyc);
    if (bus.frame_err === 1'b1) ferr_q.push_back(cyc);
    if (int'(bus.rx_done_tick) + int'(bus.parity_err) + int'(bus.frame_err) > 1) multi++;
    if (!reset && bus.dout !== last_dout && bus.rx_done_tick !== 1'b1) dout_bad++;
    last_dout = bus.dout;
  end
  typedef struct {
    logic [7:0] data;
    logic par;
    logic stop;
    logic en;
    int drop;
    logic e_done;
    logic e_perr;
    logic e_ferr;
  } vec_t;
  vec_t vecs[9];
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask
  task automatic clear_q();
    done_q.delete();
    perr_q.delete();
    ferr_q.delete();
    val_q.delete();
  endtask
  // Outcome of a whole frame from the protocol rules alone.
  function automatic void model(input logic [7:0] d, input logic par, input logic stop, input logic en,
                                output logic ed, output logic ep, output logic ef);
    ed = 1'b0;
    ep = 1'b0;
    ef = 1'b0;
    if (!en) return;
    if (!stop) ef = 1'b1;
    else if ($countones({d, par}) % 2 == 0) ep = 1'b1;
    else ed = 1'b1;
  endfunction
  task automatic send_bits(input logic [10:0] b, input int n, input int hp, input int drop, output int lf);
    lf = 0;
    for (int i = 0; i < n; i++) begin
      if (i == drop) bus.rx_en = 1'b0;
      bus.ps2d = b[i];
      tick(hp);
      bus.ps2c = 1'b0;
      lf = cyc;
      tick(hp);
      bus.ps2c = 1'b1;
    end
    bus.ps2d = 1'b1;
  endtask
  task automatic run_frame(input string tag, input logic [7:0] d, input logic par, input logic stop,
                           input logic en, input int drop, input int hp,
                           input logic ed, input logic ep, input logic ef);
    int lf;
    bus.rx_en = en;
    clear_q();
    send_bits({stop, par, d, 1'b0}, 11, hp, drop, lf);
    tick(FL + 8);
    chk({tag, " done count"}, done_q.size(), int'(ed));
    chk({tag, " parity_err count"}, perr_q.size(), int'(ep));
    chk({tag, " frame_err count"}, ferr_q.size(), int'(ef));
    if (ed && done_q.size() > 0) begin
      chk({tag, " done cycle"}, done_q[0], lf + FL + 3);
      chk({tag, " dout at done"}, int'(val_q[0]), int'(d));
      exp_dout = d;
    end
    if (ep && perr_q.size() > 0) chk({tag, " parity_err cycle"}, perr_q[0], lf + FL + 3);
    if (ef && ferr_q.size() > 0) chk({tag, " frame_err cycle"}, ferr_q[0], lf + FL + 3);
    chk({tag, " dout held"}, int'(bus.dout), int'(exp_dout));
  endtask
  initial begin
    int lf;
    logic [7:0] d;
    logic par, stop, en, ed, ep, ef;
    vecs[0] = '{8'h1D, 1'b1, 1'b1, 1'b1, -1, 1'b1, 1'b0, 1'b0};
    vecs[1] = '{8'h1D, 1'b0, 1'b1, 1'b1, -1, 1'b0, 1'b1, 1'b0};
    vecs[2] = '{8'hF0, 1'b0, 1'b0, 1'b1, -1, 1'b0, 1'b0, 1'b1};
    vecs[3] = '{8'hF0, 1'b1, 1'b1, 1'b1, -1, 1'b1, 1'b0, 1'b0};
    vecs[4] = '{8'h00, 1'b1, 1'b1, 1'b1, -1, 1'b1, 1'b0, 1'b0};
    vecs[5] = '{8'hFF, 1'b1, 1'b1, 1'b1, -1, 1'b1, 1'b0, 1'b0};
    vecs[6] = '{8'h80, 1'b0, 1'b1, 1'b1, -1, 1'b1, 1'b0, 1'b0};
    vecs[7] = '{8'h5A, 1'b1, 1'b1, 1'b1, 3, 1'b1, 1'b0, 1'b0};
    vecs[8] = '{8'h3C, 1'b1, 1'b1, 1'b0, -1, 1'b0, 1'b0, 1'b0};
    bus.ps2c = 1'b1;
    bus.ps2d = 1'b1;
    bus.rx_en = 1'b0;
    reset = 1'b1;
    tick(3);
    reset = 1'b0;
    tick(2);
    chk("reset dout", int'(bus.dout), 0);
    chk("reset rx_done_tick", int'(bus.rx_done_tick), 0);
    chk("reset parity_err", int'(bus.parity_err), 0);
    chk("reset frame_err", int'(bus.frame_err), 0);
    for (int i = 0; i < 9; i++)
      run_frame($sformatf("vec%0d", i), vecs[i].data, vecs[i].par, vecs[i].stop, vecs[i].en,
                vecs[i].drop, 20, vecs[i].e_done, vecs[i].e_perr, vecs[i].e_ferr);
    // Timeout: start plus four data bits, then the clock stays high.
    bus.rx_en = 1'b1;
    clear_q();
    send_bits(11'b000_1011_0100, 5, 15, -1, lf);
    tick(TO + FL + 15);
    chk("timeout frame_err count", ferr_q.size(), 1);
    if (ferr_q.size() > 0) chk("timeout frame_err cycle", ferr_q[0], lf + FL + 2 + TO);
    chk("timeout done count", done_q.size(), 0);
    chk("timeout dout held", int'(bus.dout), int'(exp_dout));
    run_frame("after timeout", 8'hF0, 1'b1, 1'b1, 1'b1, -1, 20, 1'b1, 1'b0, 1'b0);
    // Short low glitches with data low and receive enabled must never start a frame.
    clear_q();
    bus.rx_en = 1'b1;
    bus.ps2d = 1'b0;
    for (int i = 0; i < 4; i++) begin
      bus.ps2c = 1'b0;
      tick(FL - 1);
      bus.ps2c = 1'b1;
      tick(15);
    end
    bus.ps2d = 1'b1;
    tick(TO + FL + 20);
    chk("glitch pulses", done_q.size() + perr_q.size() + ferr_q.size(), 0);
    run_frame("rx_en low", 8'h1D, 1'b1, 1'b1, 1'b0, -1, 20, 1'b0, 1'b0, 1'b0);
    // Reset partway through 0x1C, then a complete 0x23.
    bus.rx_en = 1'b1;
    clear_q();
    send_bits({1'b1, 1'b0, 8'h1C, 1'b0}, 6, 15, -1, lf);
    tick(3);
    reset = 1'b1;
    tick(2);
    reset = 1'b0;
    exp_dout = 8'h00;
    tick(TO + 10);
    chk("mid-frame reset pulses", done_q.size() + perr_q.size() + ferr_q.size(), 0);
    chk("mid-frame reset dout", int'(bus.dout), 0);
    run_frame("after reset", 8'h23, 1'b0, 1'b1, 1'b1, -1, 20, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 24; i++) begin
      d = 8'($urandom);
      par = ~(^d) ^ ($urandom_range(0, 3) == 0);
      stop = $urandom_range(0, 4) != 0;
      en = $urandom_range(0, 6) != 0;
      model(d, par, stop, en, ed, ep, ef);
      tick($urandom_range(1, 30));
      run_frame($sformatf("rand%0d", i), d, par, stop, en, -1, $urandom_range(10, 20), ed, ep, ef);
    end
    chk("single pulse per cycle", multi, 0);
    chk("dout changes only on done", dout_bad, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
